serial_twos_complement: RTL and testbench

Bit-serial two's complement negator using one full-adder slice and a carry flip-flop. It accepts a WIDTH-bit operand over a valid/ready handshake, computes `~a + 1` one bit per clock, LSB first, and presents the parallel result on a second valid/ready handshake. It is the sequential, area-reduced counterpart of the parallel ripple negator. It sits upstream of the add/subtract datapath, supplying negated operands for subtraction.

---
 rtl/serial_twos_complement.sv | 124 ++++++++++++
 tb/tb_serial_twos_complement.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_twos_complement.sv
// serial_twos_complement: bit-serial two's complement negator.
// Computes ~a + 1 one bit per clock, LSB first, using a single full-adder
// slice and a carry flip-flop, between two valid/ready handshakes.
// Optional feature macro: SERIAL_TC_OVERFLOW_EN (drives out_overflow and
// reports overflow operands in simulation). Undefined: out_overflow = 0.
module serial_twos_complement #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sum_bit;
  logic             carry_next;

  // Full-adder slice: adds the inverted operand bit to the running carry
  // (the "+1" is the carry seeded to 1 at load).
  always_comb begin
    sum_bit    = ~operand[0] ^ carry;
    carry_next = ~operand[0] & carry;
  end

  // Handshake outputs are decoded from state only, so no input reaches them.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = result;

  // Control FSM and serial datapath: load, shift WIDTH bits, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      operand <= '0;
      result  <= '0;
      carry   <= 1'b1;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand <= in_data;
            result  <= '0;
            carry   <= 1'b1;
            count   <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          operand <= {1'b0, operand[WIDTH-1:1]};
          result  <= {sum_bit, result[WIDTH-1:1]};
          carry   <= carry_next;
          if (count == LAST_BIT) begin
            // Final bit handled this cycle; the carry out is discarded.
            count <= '0;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
            state <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_TC_OVERFLOW_EN
  logic overflow;

  assign out_overflow = overflow;

  // Overflow flag: operand is 1 followed by zeros; captured at load, held
  // until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      overflow <= in_data[WIDTH-1] & ~(|in_data[WIDTH-2:0]);
    end else begin
      overflow <= overflow;
    end
  end

  // Simulation report of overflow operands as their result is consumed.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && out_ready && overflow) begin
      $display("serial_twos_complement: overflow operand, result %b", result);
    end
  end
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_twos_complement.sv
// Self-checking bench for serial_twos_complement (WIDTH=4): table-driven
// vectors, exhaustive sweep, randomized operands against an arithmetic
// reference model, and hand-written reset/backpressure sequences.
module tb_serial_twos_complement;

  localparam int W = 4;
`ifdef SERIAL_TC_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_overflow;

  int checks = 0;
  int errors = 0;

  serial_twos_complement #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] exp_data;
    bit           exp_ovf;
    int           hold;
    bit           toggle;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: negation modulo 2^W from plain arithmetic.
  function automatic logic [W-1:0] model_neg(input logic [W-1:0] a);
    int r;
    r = ((1 << W) - int'(a)) % (1 << W);
    return W'(r);
  endfunction

  function automatic bit model_ovf(input logic [W-1:0] a);
    return OVF_EN && (int'(a) == (1 << (W - 1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, latency, result, optional backpressure,
  // optional in_valid toggling during SHIFT, then output handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] exp_d,
                       input bit exp_o, input int hold, input bit tog);
    int lat;
    check("in_ready_before_accept", int'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (tog) begin
        check("in_ready_busy", int'(in_ready), 0);
        in_valid = ~in_valid;
        in_data  = 4'b0111;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("out_data", int'(out_data), int'(exp_d));
    check("out_overflow", int'(out_overflow), int'(exp_o));
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), int'(exp_d));
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_out_valid", int'(out_valid), 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 4'b0000, exp_data: 4'b0000, exp_ovf: 1'b0,   hold: 0, toggle: 1'b0};
    vecs[1] = '{a: 4'b0001, exp_data: 4'b1111, exp_ovf: 1'b0,   hold: 0, toggle: 1'b0};
    vecs[2] = '{a: 4'b0101, exp_data: 4'b1011, exp_ovf: 1'b0,   hold: 0, toggle: 1'b0};
    vecs[3] = '{a: 4'b1111, exp_data: 4'b0001, exp_ovf: 1'b0,   hold: 0, toggle: 1'b0};
    vecs[4] = '{a: 4'b1000, exp_data: 4'b1000, exp_ovf: OVF_EN, hold: 0, toggle: 1'b0};
    vecs[5] = '{a: 4'b0011, exp_data: 4'b1101, exp_ovf: 1'b0,   hold: 5, toggle: 1'b0};
    vecs[6] = '{a: 4'b0010, exp_data: 4'b1110, exp_ovf: 1'b0,   hold: 0, toggle: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_overflow", int'(out_overflow), 0);
    rst = 1'b0;
    step();

    // Directed table vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].exp_data, vecs[i].exp_ovf, vecs[i].hold, vecs[i].toggle);
    end

    // Exhaustive sweep, back-to-back (W+2 cycle spacing).
    for (int a = 0; a < (1 << W); a++) begin
      do_op(W'(a), model_neg(W'(a)), model_ovf(W'(a)), 0, 1'b0);
    end

    // Reset in the middle of SHIFT: accept 0110, rst sampled at 2nd SHIFT edge.
    in_valid = 1'b1;
    in_data  = 4'b0110;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    for (int k = 0; k < W + 2; k++) begin
      step();
      check("midrst_no_result", int'(out_valid), 0);
    end
    do_op(4'b0001, 4'b1111, 1'b0, 0, 1'b0);

    // Randomized operands with random backpressure against the model.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      ra = W'($urandom_range(0, (1 << W) - 1));
      do_op(ra, model_neg(ra), model_ovf(ra), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
